dds_sample_packer: RTL and testbench

Downstream stage of the DDS sine generator. Takes the 12-bit DDS output samples, decimates them by a programmable ratio, and tags each kept sample with a 4-bit channel ID. It frames the samples into fixed-length packets with a sequence-numbered header and buffers them in a first-word-fall-through (FWFT) FIFO. The FIFO feeds the 16-bit USB slave-FIFO write path through a valid/ready handshake.

---
 rtl/dds_sample_packer.sv | 131 +++++++++++++
 tb/tb_dds_sample_packer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sample_packer.sv
// Decimates and tags DDS samples, frames them into sequence-numbered packets,
// and buffers the words in a first-word-fall-through FIFO for the USB write path.
module dds_sample_packer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PKT_LEN = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cap_en,
  input  logic [7:0]             dec_ratio,
  input  logic [3:0]             tag,
  input  logic [11:0]            s_data,
  input  logic                   s_valid,
  output logic [15:0]            m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   pkt_end,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned FW = 17;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t        state;
  logic [7:0]    seq;
  logic [7:0]    dec_lat;
  logic [7:0]    dec_cnt;
  logic [3:0]    tag_lat;
  logic [CW-1:0] smp_cnt;
  logic          cap_en_q;

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          full;
  logic          empty;
  logic          keep;
  logic          hdr_push;
  logic          smp_push;
  logic          push;
  logic          pop;
  logic          last_smp;
  logic [FW-1:0] push_word;

  // Push/pop decisions; a full FIFO blocks pushes even when a pop is pending.
  always_comb begin
    full      = (fifo_level == LW'(DEPTH));
    empty     = (fifo_level == '0);
    keep      = (state == DATA) && s_valid && (dec_cnt == '0);
    hdr_push  = (state == HDR) && !full;
    smp_push  = keep && !full;
    push      = hdr_push || smp_push;
    pop       = !empty && m_ready;
    last_smp  = (smp_cnt == CW'(PKT_LEN - 1));
    push_word = hdr_push ? {1'b0, 4'hA, 4'h0, seq} : {last_smp, tag_lat, s_data};
  end

  // Head entry shown straight from storage.
  assign m_valid = !empty;
  assign m_data  = mem[rd_ptr][15:0];
  assign pkt_end = !empty && mem[rd_ptr][16];

  // Framing FSM: header, then PKT_LEN kept samples, then header or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      seq      <= '0;
      dec_lat  <= '0;
      dec_cnt  <= '0;
      tag_lat  <= '0;
      smp_cnt  <= '0;
      cap_en_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cap_en_q <= cap_en;
      case (state)
        IDLE: begin
          if (cap_en && !cap_en_q) overflow <= 1'b0;
          if (cap_en) state <= HDR;
        end
        HDR: begin
          dec_lat <= dec_ratio;
          tag_lat <= tag;
          dec_cnt <= '0;
          smp_cnt <= '0;
          if (!full) state <= DATA;
        end
        DATA: begin
          if (s_valid) dec_cnt <= (dec_cnt == dec_lat) ? 8'd0 : dec_cnt + 8'd1;
          if (keep && full) overflow <= 1'b1;
          if (smp_push) begin
            smp_cnt <= smp_cnt + CW'(1);
            if (last_smp) begin
              seq   <= seq + 8'd1;
              state <= cap_en ? HDR : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage carries no reset; validity comes from the level counter.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sample_packer.sv
// Randomized and directed bench for dds_sample_packer against a queue-based
// packet model; PKT_LEN is shortened to 4 so framing boundaries come quickly.
module tb_dds_sample_packer;

  localparam int DEPTH   = 16;
  localparam int PKT_LEN = 4;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int P_IDLE  = 0;
  localparam int P_HDR   = 1;
  localparam int P_DATA  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cap_en = 1'b0;
  logic [7:0]    dec_ratio = '0;
  logic [3:0]    tag = '0;
  logic [11:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [15:0]   m_data;
  logic          m_valid;
  logic          pkt_end;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO contents as a queue, packet progress as counters.
  logic [16:0] mq[$];
  logic [16:0] acc[$];
  int          m_phase;
  bit          m_cap_prev;
  bit          m_ovf;
  bit          m_took;
  int          m_ratio;
  logic [3:0]  m_tag;
  int          m_vcount;
  int          m_words;
  int          m_seq;
  bit          cnt_mode;
  int          data_ctr;

  dds_sample_packer #(.DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .dec_ratio(dec_ratio), .tag(tag),
    .s_data(s_data), .s_valid(s_valid), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .pkt_end(pkt_end), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    m_phase = P_IDLE; m_cap_prev = 1'b0; m_ovf = 1'b0; m_took = 1'b0;
    m_ratio = 0; m_tag = '0; m_vcount = 0; m_words = 0; m_seq = 0;
  endfunction

  // One clock edge of the packer as described behaviourally.
  function automatic void model_step();
    bit          full_n = (mq.size() == DEPTH);
    bit          pop_n  = (mq.size() != 0) && (m_ready === 1'b1);
    bit          push_n = 1'b0;
    logic [16:0] w = '0;
    m_took = (m_phase == P_DATA) && (s_valid === 1'b1);
    case (m_phase)
      P_IDLE: begin
        if (cap_en && !m_cap_prev) m_ovf = 1'b0;
        if (cap_en) m_phase = P_HDR;
      end
      P_HDR: begin
        m_ratio = int'(dec_ratio); m_tag = tag; m_vcount = 0; m_words = 0;
        if (!full_n) begin
          push_n = 1'b1; w = {1'b0, 8'hA0, 8'(m_seq)}; m_phase = P_DATA;
        end
      end
      default: if (s_valid) begin
        if (m_vcount % (m_ratio + 1) == 0) begin
          if (full_n) m_ovf = 1'b1;
          else begin
            push_n = 1'b1;
            w = {(m_words == PKT_LEN - 1), m_tag, s_data};
            m_words++;
            if (m_words == PKT_LEN) begin
              m_seq = (m_seq + 1) % 256;
              m_phase = cap_en ? P_HDR : P_IDLE;
            end
          end
        end
        m_vcount++;
      end
    endcase
    m_cap_prev = cap_en;
    if (pop_n) void'(mq.pop_front());
    if (push_n) mq.push_back(w);
  endfunction

  task automatic tick();
    if (cnt_mode) s_data = 12'(data_ctr);
    if (m_valid === 1'b1 && m_ready === 1'b1) acc.push_back({pkt_end, m_data});
    model_step();
    if (cnt_mode && m_took) data_ctr++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    acc.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cap_en = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_vec++; if (pkt_end !== 1'b0) begin n_err++; $display("FAIL reset_pkt_end: got %b expected 0", pkt_end); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_vec++; if (fifo_level !== '0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [16:0] exp_w [10];
    exp_w = '{17'h0A000, 17'h03001, 17'h03002, 17'h03003, 17'h13004,
              17'h0A001, 17'h03005, 17'h03006, 17'h03007, 17'h13008};
    do_reset();
    cnt_mode = 1'b1; data_ctr = 1;
    cap_en = 1'b1; dec_ratio = 8'd0; tag = 4'd3; s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    n_vec++; if (acc.size() < 10) begin n_err++; $display("FAIL basic_count: got %0d words expected >= 10", acc.size()); end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (acc[i] !== exp_w[i]) begin n_err++; $display("FAIL basic_word%0d: got %h expected %h", i, acc[i], exp_w[i]); end
    end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_decimation();
    logic [16:0] exp_w [10];
    exp_w = '{17'h0A000, 17'h05000, 17'h05003, 17'h05006, 17'h15009,
              17'h0A001, 17'h0500A, 17'h0500B, 17'h0500C, 17'h1500D};
    do_reset();
    cnt_mode = 1'b1; data_ctr = 0;
    cap_en = 1'b1; dec_ratio = 8'd2; tag = 4'd5; s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 5) dec_ratio = 8'd0;
      tick();
    end
    n_vec++; if (acc.size() < 10) begin n_err++; $display("FAIL dec_count: got %0d words expected >= 10", acc.size()); end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (acc[i] !== exp_w[i]) begin n_err++; $display("FAIL dec_word%0d: got %h expected %h", i, acc[i], exp_w[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [16:0] exp_w [16];
    exp_w = '{17'h0A000, 17'h07001, 17'h07002, 17'h07003, 17'h17004, 17'h0A001,
              17'h07005, 17'h07006, 17'h07007, 17'h17008, 17'h0A002, 17'h07009,
              17'h0700A, 17'h0700B, 17'h1700C, 17'h0A003};
    do_reset();
    cnt_mode = 1'b1; data_ctr = 1;
    cap_en = 1'b1; dec_ratio = 8'd0; tag = 4'd7; s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    n_vec++; if (fifo_level !== LW'(16)) begin n_err++; $display("FAIL ovf_level: got %0d expected 16", fifo_level); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b expected 1", m_valid); end
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    n_vec++; if (acc.size() < 21) begin n_err++; $display("FAIL ovf_count: got %0d words expected >= 21", acc.size()); end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (acc[i] !== exp_w[i]) begin n_err++; $display("FAIL ovf_drain%0d: got %h expected %h", i, acc[i], exp_w[i]); end
    end
    for (int i = 16; i < 20; i++) begin
      n_vec++;
      if (acc[i][16] !== (i == 19) || acc[i][15:12] !== 4'h7) begin
        n_err++; $display("FAIL ovf_pkt3_word%0d: got %h expected tag 7 end=%0d", i, acc[i], (i == 19));
      end
    end
    n_vec++; if (acc[20] !== 17'h0A004) begin n_err++; $display("FAIL ovf_next_hdr: got %h expected 0a004", acc[20]); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_cap_drop();
    logic [16:0] exp_w [5];
    int          guard;
    exp_w = '{17'h0A000, 17'h02001, 17'h02002, 17'h02003, 17'h12004};
    do_reset();
    cnt_mode = 1'b1; data_ctr = 1;
    cap_en = 1'b1; dec_ratio = 8'd0; tag = 4'd2; s_valid = 1'b1; m_ready = 1'b1;
    guard = 0;
    while (!(m_phase == P_DATA && m_words == 2) && guard < 20) begin tick(); guard++; end
    n_vec++; if (guard >= 20) begin n_err++; $display("FAIL cap_reach_2: got timeout expected 2 samples packed"); end
    cap_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_vec++; if (acc.size() != 5) begin n_err++; $display("FAIL cap_word_count: got %0d expected 5", acc.size()); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (acc[i] !== exp_w[i]) begin n_err++; $display("FAIL cap_word%0d: got %h expected %h", i, acc[i], exp_w[i]); end
    end
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL cap_idle_valid: got %b expected 0", m_valid); end
    // Second round: build up overflow, stop capture mid-packet, then re-arm.
    cap_en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    cap_en = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL cap_ovf_sticky: got %b expected 1", overflow); end
    n_vec++; if (fifo_level !== '0) begin n_err++; $display("FAIL cap_drained: got %0d expected 0", fifo_level); end
    cap_en = 1'b1;
    tick();
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL cap_ovf_clear: got %b expected 0", overflow); end
    guard = 0;
    while (m_valid !== 1'b1 && guard < 5) begin tick(); guard++; end
    n_vec++;
    if ({pkt_end, m_data} !== 17'h0A005) begin n_err++; $display("FAIL cap_seq_cont: got %h expected 0a005", {pkt_end, m_data}); end
  endtask

  task automatic test_seq_wrap();
    logic [16:0] exp;
    int          k;
    do_reset();
    cnt_mode = 1'b1; data_ctr = 0;
    cap_en = 1'b1; dec_ratio = 8'd0; tag = 4'd1; s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 1300; i++) tick();
    k = 0;
    foreach (acc[i]) begin
      if (acc[i][15:12] == 4'hA) begin
        if (k <= 256) begin
          exp = {1'b0, 8'hA0, 8'(k)};
          n_vec++;
          if (acc[i] !== exp) begin n_err++; $display("FAIL seq_hdr%0d: got %h expected %h", k, acc[i], exp); end
        end
        k++;
      end
    end
    n_vec++; if (k < 257) begin n_err++; $display("FAIL seq_hdr_count: got %0d expected >= 257", k); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cnt_mode = 1'b1; data_ctr = 1;
    cap_en = 1'b1; dec_ratio = 8'd0; tag = 4'd4; s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    n_vec++; if (fifo_level !== LW'(5)) begin n_err++; $display("FAIL mid_level_pre: got %0d expected 5", fifo_level); end
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b expected 0", m_valid); end
    n_vec++; if (fifo_level !== '0) begin n_err++; $display("FAIL mid_level: got %0d expected 0", fifo_level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
    n_vec++; if (pkt_end !== 1'b0) begin n_err++; $display("FAIL mid_pkt_end: got %b expected 0", pkt_end); end
    @(posedge clk); #1;
    rst = 1'b0;
    acc.delete();
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (acc.size() == 0 || acc[0] !== 17'h0A000) begin n_err++; $display("FAIL mid_first_hdr: got %h expected 0a000", (acc.size() != 0) ? acc[0] : 17'h0); end
  endtask

  task automatic test_random();
    do_reset();
    cnt_mode = 1'b0;
    cap_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      s_valid   = ($urandom_range(0, 9) < 7);
      m_ready   = ((i % 300) < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
      dec_ratio = 8'($urandom_range(0, 3));
      tag       = 4'($urandom_range(0, 15));
      s_data    = 12'($urandom);
      if ($urandom_range(0, 49) == 0) cap_en = ~cap_en;
      tick();
      n_vec++; if (fifo_level !== LW'(mq.size())) begin n_err++; $display("FAIL rnd_level@%0d: got %0d expected %0d", i, fifo_level, mq.size()); end
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow@%0d: got %b expected %b", i, overflow, m_ovf); end
      n_vec++; if (m_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, m_valid, (mq.size() != 0)); end
      n_vec++;
      if (mq.size() != 0) begin
        if ({pkt_end, m_data} !== mq[0]) begin n_err++; $display("FAIL rnd_head@%0d: got %h expected %h", i, {pkt_end, m_data}, mq[0]); end
      end else if (pkt_end !== 1'b0) begin
        n_err++; $display("FAIL rnd_pkt_end_empty@%0d: got %b expected 0", i, pkt_end);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decimation();
    test_overflow();
    test_cap_drop();
    test_seq_wrap();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
